// File: rtl/sseg_reader_pkg.sv
// Shared 7-segment code table for the display mux encoder and the scan reader.
// Segment order is {a,b,c,d,e,f,g} with a in bit 6; segments are active-low.
package sseg_reader_pkg;

    localparam logic [6:0] BLANK = 7'h7F;

    // Index = hex value; entry 0 is the rightmost slice.
    localparam logic [15:0][6:0] SSEG_CODE = {
        7'h38, 7'h30, 7'h42, 7'h31, 7'h60, 7'h08, 7'h04, 7'h00,
        7'h0F, 7'h20, 7'h24, 7'h4C, 7'h06, 7'h12, 7'h4F, 7'h01
    };

    // Returns {legal, value}; any pattern outside the table (blank included) is illegal.
    function automatic logic [4:0] sseg_to_hex(input logic [6:0] seg);
        logic [4:0] r;
        r = 5'b0_0000;
        for (int i = 0; i < 16; i++) begin
            if (seg == SSEG_CODE[i]) r = {1'b1, 4'(i)};
        end
        return r;
    endfunction

endpackage

// File: rtl/sseg_stable_filter.sv
// Snapshots the an/sseg bus and strobes once after it has held still for STABLE_CYC cycles.
module sseg_stable_filter #(
    parameter int STABLE_CYC = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] an,
    input  logic [7:0] sseg,
    output logic       sample,
    output logic [3:0] an_p0,
    output logic [7:0] sseg_p0
);

    localparam int CW = $clog2(STABLE_CYC + 1);

    logic [CW-1:0] cnt;
    logic          same;

    assign same   = ({an, sseg} == {an_p0, sseg_p0});
    // Strobe on the edge where the counter climbs to STABLE_CYC; saturation blocks repeats.
    assign sample = same && (cnt == CW'(STABLE_CYC - 1));

    always_ff @(posedge clk) begin
        an_p0   <= an;
        sseg_p0 <= sseg;
        if (!reset) begin
            cnt <= '0;
        end else if (!same) begin
            cnt <= '0;
        end else if (cnt != CW'(STABLE_CYC)) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/sseg_scan_reader.sv
// Rebuilds four hex digits and decimal points from a multiplexed 7-segment bus.
// Optional digit timeout / stale flag enabled by defining SSEG_READER_TIMEOUT_EN.
module sseg_scan_reader
    import sseg_reader_pkg::*;
#(
    parameter int STABLE_CYC  = 16,
    parameter int TIMEOUT_CYC = 2**20
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] an,
    input  logic [7:0] sseg,
    output logic [3:0] hex3,
    output logic [3:0] hex2,
    output logic [3:0] hex1,
    output logic [3:0] hex0,
    output logic [3:0] dp,
    output logic [3:0] valid,
    output logic       frame_tick,
    output logic       seg_err,
    output logic       stale
);

    logic            sample;
    logic [3:0]      an_p0;
    logic [7:0]      sseg_p0;
    logic [3:0][3:0] digit_p1;
    logic [3:0]      mask;
    logic            onehot;
    logic [1:0]      pos;
    logic [4:0]      dec;
    logic            legal_smp;
    logic [3:0]      pos_bit;
    logic            timeout;

    sseg_stable_filter #(.STABLE_CYC(STABLE_CYC)) u_filter (
        .clk     (clk),
        .reset   (reset),
        .an      (an),
        .sseg    (sseg),
        .sample  (sample),
        .an_p0   (an_p0),
        .sseg_p0 (sseg_p0)
    );

    always_comb begin
        onehot = 1'b0;
        pos    = 2'd0;
        case (an_p0)
            4'b1110: begin onehot = 1'b1; pos = 2'd0; end
            4'b1101: begin onehot = 1'b1; pos = 2'd1; end
            4'b1011: begin onehot = 1'b1; pos = 2'd2; end
            4'b0111: begin onehot = 1'b1; pos = 2'd3; end
            default: begin onehot = 1'b0; pos = 2'd0; end
        endcase
        dec       = sseg_to_hex(sseg_p0[6:0]);
        legal_smp = sample && onehot && dec[4];
        pos_bit   = legal_smp ? (4'b0001 << pos) : 4'b0000;
    end

`ifdef SSEG_READER_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYC + 1);

    logic [TW-1:0] to_cnt;
    logic          stale_r;

    assign timeout = !legal_smp && (to_cnt == TW'(TIMEOUT_CYC - 1));
    assign stale   = stale_r;

    always_ff @(posedge clk) begin
        if (!reset) begin
            to_cnt  <= '0;
            stale_r <= 1'b0;
        end else begin
            if (legal_smp) begin
                to_cnt <= '0;
            end else if (to_cnt != TW'(TIMEOUT_CYC)) begin
                to_cnt <= to_cnt + 1'b1;
            end
            if (timeout) begin
                stale_r <= 1'b1;
            end else if (legal_smp) begin
                stale_r <= 1'b0;
            end
        end
    end
`else
    // Feature compiled out: the comparison is always false and just keeps TIMEOUT_CYC referenced.
    assign timeout = (TIMEOUT_CYC < 0);
    assign stale   = 1'b0;
`endif

    // Stage p1: per-digit registers, frame mask and error flag
    always_ff @(posedge clk) begin
        if (!reset) begin
            digit_p1   <= '0;
            dp         <= 4'hF;
            valid      <= 4'h0;
            mask       <= 4'h0;
            frame_tick <= 1'b0;
            seg_err    <= 1'b0;
        end else begin
            if (legal_smp) begin
                digit_p1[pos] <= dec[3:0];
                dp[pos]       <= sseg_p0[7];
            end
            if (sample && onehot && !dec[4]) seg_err <= 1'b1;
            frame_tick <= (mask == 4'hF);
            if (timeout) begin
                valid <= 4'h0;
                mask  <= 4'h0;
            end else begin
                valid <= valid | pos_bit;
                // A sample landing on the tick edge goes into the freshly cleared mask.
                mask  <= ((mask == 4'hF) ? 4'h0 : mask) | pos_bit;
            end
        end
    end

    assign hex0 = digit_p1[0];
    assign hex1 = digit_p1[1];
    assign hex2 = digit_p1[2];
    assign hex3 = digit_p1[3];

endmodule

// File: tb/tb_sseg_scan_reader.sv
// Directed plus randomized bench for sseg_scan_reader against a history-based reference model.
module tb_sseg_scan_reader;

    localparam int S = 16;

    logic       clk   = 1'b0;
    logic       reset = 1'b0;
    logic [3:0] an    = 4'hF;
    logic [7:0] sseg  = 8'hFF;
    logic [3:0] hex3, hex2, hex1, hex0, dp, valid;
    logic       frame_tick, seg_err, stale;

    always #5 clk = ~clk;

    sseg_scan_reader #(.STABLE_CYC(S)) u_dut (
        .clk        (clk),
        .reset      (reset),
        .an         (an),
        .sseg       (sseg),
        .hex3       (hex3),
        .hex2       (hex2),
        .hex1       (hex1),
        .hex0       (hex0),
        .dp         (dp),
        .valid      (valid),
        .frame_tick (frame_tick),
        .seg_err    (seg_err),
        .stale      (stale)
    );

    // Active-low {a..g} patterns for hex 0..F, derived from which segments each glyph lights.
    localparam logic [6:0] SEG [16] = '{
        7'h01, 7'h4F, 7'h12, 7'h06, 7'h4C, 7'h24, 7'h20, 7'h0F,
        7'h00, 7'h04, 7'h08, 7'h60, 7'h31, 7'h42, 7'h30, 7'h38
    };

    int          n_assert  = 0;
    int          n_fail    = 0;
    int          dut_ticks = 0;
    logic [3:0]  m_hex [4];
    logic [3:0]  m_dp, m_valid, m_seen;
    logic        m_err, m_tick, m_full;
    logic [11:0] hist [$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [4:0] decode(input logic [6:0] s);
        logic [4:0] r;
        r = 5'b0;
        for (int i = 0; i < 16; i++) if (SEG[i] == s) r = {1'b1, 4'(i)};
        return r;
    endfunction

    // A sample happens when the last S+1 edge values (counting from reset) are identical
    // and the run has only just reached that length.
    task automatic model_edge();
        logic [11:0] cur;
        logic        fire;
        logic [4:0]  d;
        int          k, n;
        cur = {an, sseg};
        if (!reset) begin
            for (int i = 0; i < 4; i++) m_hex[i] = 4'h0;
            m_dp = 4'hF; m_valid = 4'h0; m_seen = 4'h0;
            m_err = 1'b0; m_tick = 1'b0; m_full = 1'b0;
            hist.delete();
            hist.push_back(cur);
        end else begin
            hist.push_back(cur);
            if (hist.size() > S + 2) void'(hist.pop_front());
            n = hist.size();
            fire = (n >= S + 1);
            for (int i = 1; i <= S + 1; i++) if (i <= n && hist[n - i] != cur) fire = 1'b0;
            if (n == S + 2 && hist[0] == cur) fire = 1'b0;
            m_tick = m_full;
            if (m_full) m_seen = 4'h0;
            if (fire && $countones(~an) == 1) begin
                k = 0;
                for (int i = 0; i < 4; i++) if (!an[i]) k = i;
                d = decode(sseg[6:0]);
                if (d[4]) begin
                    m_hex[k]   = d[3:0];
                    m_dp[k]    = sseg[7];
                    m_valid[k] = 1'b1;
                    m_seen[k]  = 1'b1;
                end else begin
                    m_err = 1'b1;
                end
            end
            m_full = (m_seen == 4'hF);
        end
    endtask

    task automatic step(input logic [3:0] a, input logic [7:0] s, input logic r);
        an = a; sseg = s; reset = r;
        @(posedge clk);
        model_edge();
        #1;
        if (frame_tick === 1'b1) dut_ticks++;
        check("hex",   32'({hex3, hex2, hex1, hex0}), 32'({m_hex[3], m_hex[2], m_hex[1], m_hex[0]}));
        check("dp",    32'(dp),         32'(m_dp));
        check("valid", 32'(valid),      32'(m_valid));
        check("tick",  32'(frame_tick), 32'(m_tick));
        check("err",   32'(seg_err),    32'(m_err));
        check("stale", 32'(stale),      32'h0);
    endtask

    task automatic hold(input logic [3:0] a, input logic [7:0] s, input int n);
        for (int i = 0; i < n; i++) step(a, s, 1'b1);
    endtask

    initial begin
        logic [3:0] ra;
        logic [7:0] rs;

        // Reset state
        for (int i = 0; i < 3; i++) step(4'hF, 8'hFF, 1'b0);
        check("rst_hex",   32'({hex3, hex2, hex1, hex0}), 32'h0);
        check("rst_dp",    32'(dp), 32'hF);
        check("rst_valid", 32'(valid), 32'h0);

        // Single digit 'A' on an0: sampled on the 17th held edge, not before
        hold(4'b1110, {1'b1, 7'h08}, 16);
        check("d1_early", 32'(valid), 32'h0);
        hold(4'b1110, {1'b1, 7'h08}, 1);
        check("d1_valid", 32'(valid), 32'h1);
        check("d1_hex0",  32'(hex0), 32'hA);

        // Scan 1,2,3,4 on an3..an0
        dut_ticks = 0;
        hold(4'b0111, {1'b1, 7'h4F}, 100);
        hold(4'b1011, {1'b1, 7'h12}, 100);
        hold(4'b1101, {1'b1, 7'h06}, 100);
        hold(4'b1110, {1'b1, 7'h4C}, 100);
        check("scan_ticks", 32'(dut_ticks), 32'd1);
        check("scan_hex",   32'({hex3, hex2, hex1, hex0}), 32'h1234);
        check("scan_dp",    32'(dp), 32'hF);

        // Bus toggling faster than the filter: nothing captured
        for (int i = 0; i < 8; i++) hold(4'b1110, (i % 2) ? 8'h00 : 8'h01, 5);
        check("tog_hex", 32'({hex3, hex2, hex1, hex0}), 32'h1234);
        check("tog_dp",  32'(dp), 32'hF);

        // Two anodes low is ignored silently; blank code flags a sticky error
        hold(4'b1100, {1'b1, 7'h00}, 50);
        check("an2_err", 32'(seg_err), 32'h0);
        hold(4'b0111, 8'hFF, 30);
        check("blank_err", 32'(seg_err), 32'h1);
        hold(4'b0111, {1'b0, 7'h38}, 30);
        check("sticky_err", 32'(seg_err), 32'h1);
        check("sticky_hex3", 32'(hex3), 32'hF);

        // Reset mid-frame discards partial progress
        hold(4'b1110, {1'b0, 7'h00}, 30);
        hold(4'b1101, {1'b0, 7'h04}, 30);
        step(4'b1101, {1'b0, 7'h04}, 1'b0);
        step(4'b1101, {1'b0, 7'h04}, 1'b0);
        check("mid_valid", 32'(valid), 32'h0);
        check("mid_err",   32'(seg_err), 32'h0);
        check("mid_dp",    32'(dp), 32'hF);
        dut_ticks = 0;
        hold(4'b0111, {1'b1, 7'h60}, 40);
        hold(4'b1011, {1'b1, 7'h31}, 40);
        hold(4'b1101, {1'b1, 7'h42}, 40);
        check("mid_noticks", 32'(dut_ticks), 32'd0);
        hold(4'b1110, {1'b1, 7'h30}, 40);
        check("mid_tick", 32'(dut_ticks), 32'd1);
        check("mid_hex",  32'({hex3, hex2, hex1, hex0}), 32'hBCDE);

        // Randomized segments, hold lengths straddling the filter threshold, occasional resets
        for (int n = 0; n < 300; n++) begin
            ra = ($urandom_range(0, 4) != 0) ? ~(4'b0001 << $urandom_range(0, 3)) : 4'($urandom);
            rs = ($urandom_range(0, 9) != 0) ? {1'($urandom), SEG[$urandom_range(0, 15)]}
                                             : 8'($urandom);
            if ($urandom_range(0, 39) == 0) begin
                for (int i = 0; i < $urandom_range(1, 3); i++) step(ra, rs, 1'b0);
            end
            hold(ra, rs, $urandom_range(1, 40));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
